// File: rtl/decode_stage_sb.sv
// decode_stage_sb: decode stage with register file, write-back bypass,
// register scoreboard, hazard stall and a valid/ready ID/EX register.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-low reset
//   id_valid_i/id_ready_o   instruction handshake at decode (id_ready_o is combinational)
//   rs_i, rt_i, rd_i        source 1, source 2 / I-type dest, R-type dest
//   uses_rs_i, uses_rt_i    instruction reads rs / rt
//   reg_dst_i, reg_write_i  dest select (1 = rd, 0 = rt), writes a register
//   imm_i, imm_mode_i       raw immediate, extension mode
//   wb_en_i/addr_i/data_i   write-back port
//   flush_i                 discard ID instruction and ID/EX contents
//   ex_ready_i/ex_valid_o   ID/EX handshake
//   ex_*_o                  registered bundle to EX
//   busy_vec_o              scoreboard, bit i = write pending to register i
module decode_stage_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned IMM_W = 16,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [AW-1:0]      rs_i,
  input  logic [AW-1:0]      rt_i,
  input  logic [AW-1:0]      rd_i,
  input  logic               uses_rs_i,
  input  logic               uses_rt_i,
  input  logic               reg_dst_i,
  input  logic               reg_write_i,
  input  logic [IMM_W-1:0]   imm_i,
  input  logic [1:0]         imm_mode_i,
  input  logic               wb_en_i,
  input  logic [AW-1:0]      wb_addr_i,
  input  logic [XLEN-1:0]    wb_data_i,
  input  logic               flush_i,
  input  logic               ex_ready_i,
  output logic               ex_valid_o,
  output logic [XLEN-1:0]    ex_rs_data_o,
  output logic [XLEN-1:0]    ex_rt_data_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [IMM_W-1:0]   ex_imm_raw_o,
  output logic [AW-1:0]      ex_dst_o,
  output logic               ex_reg_write_o,
  output logic [NREGS-1:0]   busy_vec_o
);

  localparam int unsigned EXT_W = XLEN - IMM_W;

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_rs_data_q, ex_rs_data_d;
  logic [XLEN-1:0]  ex_rt_data_q, ex_rt_data_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [IMM_W-1:0] ex_imm_raw_q, ex_imm_raw_d;
  logic [AW-1:0]    ex_dst_q, ex_dst_d;
  logic             ex_reg_write_q, ex_reg_write_d;

  logic [NREGS-1:0] clr_vec, set_vec, sq_vec;
  logic [AW-1:0]    dst;
  logic [XLEN-1:0]  rs_data, rt_data, imm_sext, imm_ext;
  logic             raw_rs, raw_rt, waw, slot_free, issue;

  // Operand read with write-back bypass; register 0 reads zero.
  always_comb begin
    rs_data = rf_q[rs_i];
    rt_data = rf_q[rt_i];
    if (wb_en_i && (wb_addr_i == rs_i)) rs_data = wb_data_i;
    if (wb_en_i && (wb_addr_i == rt_i)) rt_data = wb_data_i;
    if (rs_i == '0) rs_data = '0;
    if (rt_i == '0) rt_data = '0;
  end

  // Immediate extension.
  always_comb begin
    imm_sext = {{EXT_W{imm_i[IMM_W-1]}}, imm_i};
    imm_ext  = imm_sext;
    case (imm_mode_i)
      2'd0:    imm_ext = imm_sext;
      2'd1:    imm_ext = {{EXT_W{1'b0}}, imm_i};
      2'd2:    imm_ext = {imm_i, {EXT_W{1'b0}}};
      default: imm_ext = imm_sext << 2;
    endcase
  end

  // Hazard detection, issue and scoreboard next state.
  always_comb begin
    dst     = reg_dst_i ? rd_i : rt_i;
    clr_vec = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      clr_vec[i] = wb_en_i && (wb_addr_i == AW'(i));
    end

    // A register being written back this cycle no longer blocks.
    raw_rs = uses_rs_i   && (rs_i != '0) && busy_q[rs_i] && !clr_vec[rs_i];
    raw_rt = uses_rt_i   && (rt_i != '0) && busy_q[rt_i] && !clr_vec[rt_i];
    waw    = reg_write_i && (dst  != '0) && busy_q[dst]  && !clr_vec[dst];

    slot_free  = !ex_valid_q || ex_ready_i;
    id_ready_o = reset_i && slot_free && !(raw_rs || raw_rt || waw) && !flush_i;
    issue      = id_valid_i && id_ready_o;

    set_vec = '0;
    if (issue && reg_write_i && (dst != '0)) set_vec[dst] = 1'b1;

    // Flushing a writer held in ID/EX releases its destination.
    sq_vec = '0;
    if (flush_i && ex_valid_q && ex_reg_write_q && (ex_dst_q != '0)) sq_vec[ex_dst_q] = 1'b1;

    busy_d    = ((busy_q & ~clr_vec) | set_vec) & ~sq_vec;
    busy_d[0] = 1'b0;
  end

  // ID/EX register next state.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    ex_imm_raw_d   = ex_imm_raw_q;
    ex_dst_d       = ex_dst_q;
    ex_reg_write_d = ex_reg_write_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d     = 1'b1;
      ex_rs_data_d   = rs_data;
      ex_rt_data_d   = rt_data;
      ex_imm_d       = imm_ext;
      ex_imm_raw_d   = imm_i;
      ex_dst_d       = dst;
      ex_reg_write_d = reg_write_i;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  // Register file; entry 0 is never written.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Scoreboard and ID/EX state.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      busy_q         <= '0;
      ex_valid_q     <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_imm_raw_q   <= '0;
      ex_dst_q       <= '0;
      ex_reg_write_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      ex_valid_q     <= ex_valid_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_imm_raw_q   <= ex_imm_raw_d;
      ex_dst_q       <= ex_dst_d;
      ex_reg_write_q <= ex_reg_write_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_rs_data_o   = ex_rs_data_q;
  assign ex_rt_data_o   = ex_rt_data_q;
  assign ex_imm_o       = ex_imm_q;
  assign ex_imm_raw_o   = ex_imm_raw_q;
  assign ex_dst_o       = ex_dst_q;
  assign ex_reg_write_o = ex_reg_write_q;
  assign busy_vec_o     = busy_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Testbench for decode_stage_sb: directed plan steps followed by random
// traffic, all checked against a behavioural model of the decode stage.
module tb_decode_stage_sb;

  localparam int unsigned XLEN = 32, NREGS = 32, IMM_W = 16, AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, id_valid, uses_rs, uses_rt, reg_dst, reg_write;
  logic             wb_en, flush, ex_ready;
  logic [AW-1:0]    rs, rt, rd, wb_addr;
  logic [IMM_W-1:0] imm;
  logic [1:0]       imm_mode;
  logic [XLEN-1:0]  wb_data;
  logic             id_ready, ex_valid, ex_reg_write;
  logic [XLEN-1:0]  ex_rs_data, ex_rt_data, ex_imm;
  logic [IMM_W-1:0] ex_imm_raw;
  logic [AW-1:0]    ex_dst;
  logic [NREGS-1:0] busy_vec;

  decode_stage_sb #(.XLEN(XLEN), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
    .clk_i(clk), .reset_i(reset_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .uses_rs_i(uses_rs), .uses_rt_i(uses_rt),
    .reg_dst_i(reg_dst), .reg_write_i(reg_write),
    .imm_i(imm), .imm_mode_i(imm_mode),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .flush_i(flush), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
    .ex_imm_o(ex_imm), .ex_imm_raw_o(ex_imm_raw), .ex_dst_o(ex_dst),
    .ex_reg_write_o(ex_reg_write), .busy_vec_o(busy_vec)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  logic [XLEN-1:0]  m_rf [NREGS];
  logic [NREGS-1:0] m_busy;
  logic             m_exv, m_exw;
  logic [XLEN-1:0]  m_exrs, m_exrt, m_eximm;
  logic [IMM_W-1:0] m_exraw;
  logic [AW-1:0]    m_exd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] m_ext(input logic [IMM_W-1:0] v, input logic [1:0] m);
    int s;
    s = int'($signed(v));
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(v);
      2'd2:    return 32'(v) << 16;
      default: return 32'(s * 4);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] r);
    if (r == 0) return '0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic pending(input logic [AW-1:0] r);
    return (r != 0) && m_busy[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic logic m_ready();
    logic [AW-1:0] d;
    d = reg_dst ? rd : rt;
    if (!reset_n || flush) return 1'b0;
    if (m_exv && !ex_ready) return 1'b0;
    if (uses_rs && pending(rs)) return 1'b0;
    if (uses_rt && pending(rt)) return 1'b0;
    if (reg_write && pending(d)) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock using the inputs sampled at the edge.
  task automatic m_step();
    logic iss;
    logic [AW-1:0] d;
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) m_rf[i] = '0;
      m_busy = '0; m_exv = 0; m_exw = 0; m_exrs = '0; m_exrt = '0;
      m_eximm = '0; m_exraw = '0; m_exd = '0;
    end else begin
      iss = id_valid && m_ready();
      d   = reg_dst ? rd : rt;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (iss && reg_write && d != 0) m_busy[d] = 1'b1;
      if (flush && m_exv && m_exw && m_exd != 0) m_busy[m_exd] = 1'b0;
      if (flush) m_exv = 1'b0;
      else if (iss) begin
        m_exv = 1'b1; m_exrs = m_read(rs); m_exrt = m_read(rt);
        m_eximm = m_ext(imm, imm_mode); m_exraw = imm; m_exd = d; m_exw = reg_write;
      end else if (ex_ready) m_exv = 1'b0;
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  endtask

  task automatic check_outs();
    chk("ex_valid", 64'(ex_valid), 64'(m_exv));
    chk("ex_rs_data", 64'(ex_rs_data), 64'(m_exrs));
    chk("ex_rt_data", 64'(ex_rt_data), 64'(m_exrt));
    chk("ex_imm", 64'(ex_imm), 64'(m_eximm));
    chk("ex_imm_raw", 64'(ex_imm_raw), 64'(m_exraw));
    chk("ex_dst", 64'(ex_dst), 64'(m_exd));
    chk("ex_reg_write", 64'(ex_reg_write), 64'(m_exw));
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  // One clock: check id_ready (model, and plan constant if exp_rdy >= 0),
  // clock, advance model, check registered outputs.
  task automatic cycle(input int exp_rdy);
    #1;
    chk("id_ready", 64'(id_ready), 64'(m_ready()));
    if (exp_rdy >= 0) chk("id_ready_plan", 64'(id_ready), 64'(exp_rdy));
    @(posedge clk);
    m_step();
    #1;
    check_outs();
  endtask

  task automatic idle();
    id_valid = 0; uses_rs = 0; uses_rt = 0; reg_dst = 0; reg_write = 0;
    rs = '0; rt = '0; rd = '0; imm = '0; imm_mode = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0; ex_ready = 1;
  endtask

  logic [XLEN-1:0]  exp_imm [4];
  logic [NREGS-1:0] busy_snap;

  initial begin
    exp_imm[0] = 32'hFFFF8001; exp_imm[1] = 32'h00008001;
    exp_imm[2] = 32'h80010000; exp_imm[3] = 32'hFFFE0004;
    idle();
    reset_n = 0;
    @(posedge clk);
    m_step();
    #1;
    // Reset state.
    cycle(0);
    cycle(0);
    chk("reset_busy", 64'(busy_vec), 64'h0);
    chk("reset_ex_valid", 64'(ex_valid), 64'h0);

    // Write back r5 then read it.
    reset_n = 1;
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'h1234;
    cycle(1);
    idle(); id_valid = 1; uses_rs = 1; rs = 5'd5;
    cycle(1);
    chk("plan_rs5", 64'(ex_rs_data), 64'h1234);

    // RAW on r3 resolved by write-back bypass.
    idle(); id_valid = 1; reg_write = 1; reg_dst = 1; rd = 5'd3;
    cycle(1);
    idle(); id_valid = 1; uses_rs = 1; rs = 5'd3; reg_write = 1; reg_dst = 1; rd = 5'd3;
    cycle(0);
    chk("plan_busy3_stall", 64'(busy_vec[3]), 64'h1);
    cycle(0);
    wb_en = 1; wb_addr = 5'd3; wb_data = 32'hCAFE;
    cycle(1);
    chk("plan_bypass", 64'(ex_rs_data), 64'hCAFE);
    chk("plan_busy3_reset", 64'(busy_vec[3]), 64'h1);
    idle(); wb_en = 1; wb_addr = 5'd3; wb_data = 32'h55;
    cycle(1);

    // Immediate modes.
    for (int m = 0; m < 4; m++) begin
      idle(); id_valid = 1; imm = 16'h8001; imm_mode = 2'(m);
      cycle(1);
      chk("plan_imm_mode", 64'(ex_imm), 64'(exp_imm[m]));
    end

    // Back-pressure holds the bundle.
    idle(); id_valid = 1; imm = 16'h00AB; imm_mode = 2'd1;
    cycle(1);
    idle(); id_valid = 1; ex_ready = 0; imm = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      cycle(0);
      chk("plan_hold_imm", 64'(ex_imm), 64'hAB);
      chk("plan_hold_valid", 64'(ex_valid), 64'h1);
    end
    ex_ready = 1;
    cycle(1);
    chk("plan_release_raw", 64'(ex_imm_raw), 64'h7777);

    // Flush squashes a writer to r7.
    idle(); id_valid = 1; reg_write = 1; reg_dst = 1; rd = 5'd7;
    cycle(1);
    chk("plan_busy7_set", 64'(busy_vec[7]), 64'h1);
    idle(); ex_ready = 0; flush = 1; id_valid = 1; reg_write = 1; reg_dst = 1; rd = 5'd9;
    cycle(0);
    chk("plan_flush_valid", 64'(ex_valid), 64'h0);
    chk("plan_flush_busy7", 64'(busy_vec[7]), 64'h0);
    chk("plan_flush_busy9", 64'(busy_vec[9]), 64'h0);

    // Register 0 stays zero and never becomes busy.
    idle(); wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    cycle(1);
    idle(); id_valid = 1; uses_rs = 1; rs = 5'd0; uses_rt = 1; rt = 5'd0;
    cycle(1);
    chk("plan_r0_read", 64'(ex_rs_data), 64'h0);
    busy_snap = m_busy;
    idle(); id_valid = 1; reg_write = 1; reg_dst = 0; rt = 5'd0;
    cycle(1);
    chk("plan_r0_busy", 64'(busy_vec), 64'(busy_snap));

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      id_valid  = ($urandom_range(0, 3) != 0);
      uses_rs   = 1'($urandom); uses_rt = 1'($urandom);
      reg_dst   = 1'($urandom); reg_write = 1'($urandom);
      rs        = AW'($urandom_range(0, 7));
      rt        = AW'($urandom_range(0, 7));
      rd        = AW'($urandom_range(0, 7));
      imm       = IMM_W'($urandom); imm_mode = 2'($urandom);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 199) != 0);
      cycle(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
